// File: rtl/tpu_pkg.sv
// Shared definitions for the Mini-TPU sequencer: opcodes, FSM states and
// instruction field offsets as functions of the operand width.
package tpu_pkg;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    function automatic int unsigned instr_width(input int unsigned dw);
        return dw + 12;
    endfunction

    function automatic int unsigned op_lsb(input int unsigned dw);
        return dw + 10;
    endfunction

    function automatic int unsigned sel_bit(input int unsigned dw);
        return dw + 9;
    endfunction

    function automatic int unsigned clr_bit(input int unsigned dw);
        return dw + 8;
    endfunction

    function automatic int unsigned row_lsb(input int unsigned dw);
        return dw + 4;
    endfunction

    function automatic int unsigned col_lsb(input int unsigned dw);
        return dw;
    endfunction

endpackage

// File: rtl/tpu_sequencer_if.sv
// Instruction valid/ready channel into the Mini-TPU sequencer.
interface tpu_sequencer_if
    import tpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned INSTR_W = instr_width(DATA_WIDTH);

    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;

    modport master (output instr, output instr_valid, input instr_ready);
    modport slave  (input instr, input instr_valid, output instr_ready);

endinterface

// File: rtl/tpu_skew_gen.sv
// Skewed per-lane read enable / element select: lane i reads elements
// 0..N-1 while cnt runs from i+1 to i+N.
module tpu_skew_gen #(
    parameter int unsigned ARRAY_SIZE = 4,
    parameter int unsigned CNT_W      = 4,
    localparam int unsigned IDX_W     = $clog2(ARRAY_SIZE)
) (
    input  logic                        run,
    input  logic [CNT_W-1:0]            cnt,
    output logic [ARRAY_SIZE-1:0]       read_enable,
    output logic [ARRAY_SIZE*IDX_W-1:0] read_elem
);

    always_comb begin
        read_enable = '0;
        read_elem   = '0;
        for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
            if (run && (cnt >= CNT_W'(i + 1)) && (cnt <= CNT_W'(i + ARRAY_SIZE))) begin
                read_enable[i]              = 1'b1;
                read_elem[i*IDX_W +: IDX_W] = IDX_W'(cnt - CNT_W'(i + 1));
            end
        end
    end

endmodule

// File: rtl/tpu_sequencer.sv
// Mini-TPU control unit: decodes LOAD/STORE/START/STOP instructions and runs
// the RUN/DRAIN/DONE sequence that feeds the NxN systolic array.
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE   = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DRAIN_CYCLES = ARRAY_SIZE,
    localparam int unsigned IDX_W       = $clog2(ARRAY_SIZE),
    localparam int unsigned INSTR_W     = instr_width(DATA_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    tpu_sequencer_if.slave              cmd,
    output logic [DATA_WIDTH-1:0]       mema_data_in,
    output logic [DATA_WIDTH-1:0]       memb_data_in,
    output logic                        mema_write_enable,
    output logic                        memb_write_enable,
    output logic [IDX_W-1:0]            mema_write_line,
    output logic [IDX_W-1:0]            memb_write_line,
    output logic [IDX_W-1:0]            mema_write_elem,
    output logic [IDX_W-1:0]            memb_write_elem,
    output logic [ARRAY_SIZE-1:0]       read_enable,
    output logic [ARRAY_SIZE*IDX_W-1:0] read_elem,
    output logic                        array_enable,
    output logic                        array_clear,
    output logic [IDX_W-1:0]            array_output_row,
    output logic [IDX_W-1:0]            array_output_column,
    output logic                        busy,
    output logic                        done,
    output logic                        cmd_error
);

    localparam int unsigned CNT_MAX =
        (2 * ARRAY_SIZE > DRAIN_CYCLES) ? 2 * ARRAY_SIZE : DRAIN_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned OP_LSB  = op_lsb(DATA_WIDTH);
    localparam int unsigned SEL_BIT = sel_bit(DATA_WIDTH);
    localparam int unsigned CLR_BIT = clr_bit(DATA_WIDTH);
    localparam int unsigned ROW_LSB = row_lsb(DATA_WIDTH);
    localparam int unsigned COL_LSB = col_lsb(DATA_WIDTH);

    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(2 * ARRAY_SIZE);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [4:0]       IDX_LIMIT  = 5'(ARRAY_SIZE);

    logic [INSTR_W-1:0]    instr;
    logic [1:0]            op;
    logic                  sel, clr;
    logic [3:0]            row, col;
    logic [DATA_WIDTH-1:0] imm;
    logic                  ready, accept, in_range, is_mem_op, run;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              clr_q, clr_d;

    assign instr = cmd.instr;
    assign op    = instr[OP_LSB +: 2];
    assign sel   = instr[SEL_BIT];
    assign clr   = instr[CLR_BIT];
    assign row   = instr[ROW_LSB +: 4];
    assign col   = instr[COL_LSB +: 4];
    assign imm   = instr[DATA_WIDTH-1:0];

    // STOP must be accepted mid-run, so ready also depends on the opcode.
    assign ready           = (state_q == IDLE) || (op == OP_STOP);
    assign cmd.instr_ready = ready;
    assign accept          = cmd.instr_valid && ready;
    assign in_range        = ({1'b0, row} < IDX_LIMIT) && ({1'b0, col} < IDX_LIMIT);
    assign is_mem_op       = (op == OP_LOAD) || (op == OP_STORE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_d   = clr_q;
        unique case (state_q)
            IDLE: begin
                if (accept && (op == OP_START)) begin
                    state_d = RUN;
                    cnt_d   = CNT_ONE;
                    clr_d   = clr;
                end
            end
            RUN: begin
                if (accept && (op == OP_STOP)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == RUN_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DRAIN: begin
                if (accept && (op == OP_STOP)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        run         = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        array_clear = 1'b0;
        unique case (state_q)
            RUN: begin
                run         = 1'b1;
                busy        = 1'b1;
                array_clear = clr_q && (cnt_q == CNT_ONE);
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
        array_enable = busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mema_data_in        <= '0;
            memb_data_in        <= '0;
            mema_write_enable   <= 1'b0;
            memb_write_enable   <= 1'b0;
            mema_write_line     <= '0;
            memb_write_line     <= '0;
            mema_write_elem     <= '0;
            memb_write_elem     <= '0;
            array_output_row    <= '0;
            array_output_column <= '0;
            cmd_error           <= 1'b0;
        end else begin
            mema_write_enable <= 1'b0;
            memb_write_enable <= 1'b0;
            cmd_error         <= accept && is_mem_op && !in_range;
            if (accept && in_range) begin
                if (op == OP_LOAD) begin
                    if (sel) begin
                        memb_write_enable <= 1'b1;
                        memb_data_in      <= imm;
                        memb_write_line   <= row[IDX_W-1:0];
                        memb_write_elem   <= col[IDX_W-1:0];
                    end else begin
                        mema_write_enable <= 1'b1;
                        mema_data_in      <= imm;
                        mema_write_line   <= row[IDX_W-1:0];
                        mema_write_elem   <= col[IDX_W-1:0];
                    end
                end else if (op == OP_STORE) begin
                    array_output_row    <= row[IDX_W-1:0];
                    array_output_column <= col[IDX_W-1:0];
                end
            end
        end
    end

    tpu_skew_gen #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .CNT_W      (CNT_W)
    ) u_skew_gen (
        .run         (run),
        .cnt         (cnt_q),
        .read_enable (read_enable),
        .read_elem   (read_elem)
    );

endmodule

// File: tb/tb_tpu_sequencer.sv
// Randomised scoreboard bench for tpu_sequencer (N=4) plus an N=8 timing run.
module tb_tpu_sequencer;
    import tpu_pkg::*;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int D   = 4;
    localparam int IW  = 2;
    localparam int N8  = 8;
    localparam int IW8 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst8_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    tpu_sequencer_if #(.DATA_WIDTH(DW)) cmd ();
    tpu_sequencer_if #(.DATA_WIDTH(DW)) cmd8 ();

    logic [DW-1:0]   mema_data_in, memb_data_in;
    logic            mema_write_enable, memb_write_enable;
    logic [IW-1:0]   mema_write_line, memb_write_line, mema_write_elem, memb_write_elem;
    logic [N-1:0]    read_enable;
    logic [N*IW-1:0] read_elem;
    logic            array_enable, array_clear, busy, done, cmd_error;
    logic [IW-1:0]   array_output_row, array_output_column;

    logic [DW-1:0]     a8_data, b8_data;
    logic              a8_we, b8_we;
    logic [IW8-1:0]    a8_line, b8_line, a8_elem, b8_elem, row8, col8;
    logic [N8-1:0]     re8;
    logic [N8*IW8-1:0] rel8;
    logic              en8, clr8, busy8, done8, err8;

    tpu_sequencer #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .DRAIN_CYCLES(D)) dut (
        .clk (clk), .rst_n (rst_n), .cmd (cmd),
        .mema_data_in (mema_data_in), .memb_data_in (memb_data_in),
        .mema_write_enable (mema_write_enable), .memb_write_enable (memb_write_enable),
        .mema_write_line (mema_write_line), .memb_write_line (memb_write_line),
        .mema_write_elem (mema_write_elem), .memb_write_elem (memb_write_elem),
        .read_enable (read_enable), .read_elem (read_elem),
        .array_enable (array_enable), .array_clear (array_clear),
        .array_output_row (array_output_row), .array_output_column (array_output_column),
        .busy (busy), .done (done), .cmd_error (cmd_error)
    );

    tpu_sequencer #(.ARRAY_SIZE(N8), .DATA_WIDTH(DW)) dut8 (
        .clk (clk), .rst_n (rst8_n), .cmd (cmd8),
        .mema_data_in (a8_data), .memb_data_in (b8_data),
        .mema_write_enable (a8_we), .memb_write_enable (b8_we),
        .mema_write_line (a8_line), .memb_write_line (b8_line),
        .mema_write_elem (a8_elem), .memb_write_elem (b8_elem),
        .read_enable (re8), .read_elem (rel8),
        .array_enable (en8), .array_clear (clr8),
        .array_output_row (row8), .array_output_column (col8),
        .busy (busy8), .done (done8), .cmd_error (err8)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: one run described by its start cycle; cycle labels are
    // posedge counts, so a transaction accepted at edge e is visible in cycle e.
    bit have_run = 1'b0;
    int run_start = 0;
    int run_stop = 0;
    bit run_clr = 1'b0;

    typedef struct {int cyc; bit sel; logic [IW-1:0] line; logic [IW-1:0] elem;
                    logic [DW-1:0] data;} wr_t;
    typedef struct {int cyc; logic [IW-1:0] row; logic [IW-1:0] col;} st_t;
    wr_t wr_q[$];
    st_t st_q[$];
    int  err_q[$];
    logic [IW-1:0] exp_row = '0;
    logic [IW-1:0] exp_col = '0;

    function automatic bit active(input int c);
        return have_run && c >= run_start && c <= run_start + 2 * N + D && c < run_stop;
    endfunction

    function automatic logic [19:0] mk(input logic [1:0] op, input bit sel, input bit clr,
                                       input int row, input int col, input int imm);
        return {op, sel, clr, 4'(row), 4'(col), 8'(imm)};
    endfunction

    int m_c, m_k;
    bit m_a, m_busy, m_done, m_clr, m_ew, m_err;
    logic [N-1:0] m_re;
    logic [N*IW-1:0] m_el;
    wr_t m_w;
    st_t m_s;

    always @(negedge clk) begin
        if (rst_n) begin
            m_c = cyc;
            m_k = m_c - run_start;
            m_a = active(m_c);
            m_busy = m_a && m_k < 2 * N + D;
            m_done = m_a && m_k == 2 * N + D;
            m_clr = m_a && m_k == 0 && run_clr;
            m_re = '0;
            m_el = '0;
            for (int i = 0; i < N; i++) begin
                if (m_a && m_k >= i && m_k <= i + N - 1) begin
                    m_re[i] = 1'b1;
                    m_el[i*IW +: IW] = IW'(m_k - i);
                end
            end
            chk("status", {busy, array_enable, done, array_clear},
                {m_busy, m_busy, m_done, m_clr});
            chk("reads", {read_enable, read_elem}, {m_re, m_el});

            m_ew = wr_q.size() > 0 && wr_q[0].cyc == m_c;
            if (m_ew) m_w = wr_q.pop_front();
            chk("wr_strobe", {mema_write_enable, memb_write_enable},
                {m_ew && !m_w.sel, m_ew && m_w.sel});
            if (m_ew && !m_w.sel)
                chk("wr_a", {mema_write_line, mema_write_elem, mema_data_in},
                    {m_w.line, m_w.elem, m_w.data});
            if (m_ew && m_w.sel)
                chk("wr_b", {memb_write_line, memb_write_elem, memb_data_in},
                    {m_w.line, m_w.elem, m_w.data});

            m_err = err_q.size() > 0 && err_q[0] == m_c;
            if (m_err) void'(err_q.pop_front());
            chk("cmd_error", cmd_error, m_err);

            if (st_q.size() > 0 && st_q[0].cyc == m_c) begin
                m_s = st_q.pop_front();
                exp_row = m_s.row;
                exp_col = m_s.col;
            end
            chk("store_sel", {array_output_row, array_output_column}, {exp_row, exp_col});
        end
    end

    task automatic drive(input bit v, input logic [19:0] ins);
        int c;
        int e;
        bit rdy;
        logic [1:0] op;
        logic [3:0] row, col;
        @(negedge clk);
        cmd.instr = ins;
        cmd.instr_valid = v;
        #1;
        c = cyc;
        e = c + 1;
        op = ins[19:18];
        row = ins[15:12];
        col = ins[11:8];
        rdy = !active(c) || op == OP_STOP;
        chk("instr_ready", cmd.instr_ready, rdy);
        if (v && rdy) begin
            case (op)
                OP_START: begin
                    have_run = 1'b1;
                    run_start = e;
                    run_stop = 32'h7fff_ffff;
                    run_clr = ins[16];
                end
                OP_STOP: if (active(c) && c - run_start < 2 * N + D) run_stop = e;
                OP_LOAD: begin
                    if (row < N && col < N)
                        wr_q.push_back('{e, ins[17], row[IW-1:0], col[IW-1:0], ins[7:0]});
                    else err_q.push_back(e);
                end
                default: begin
                    if (row < N && col < N) st_q.push_back('{e, row[IW-1:0], col[IW-1:0]});
                    else err_q.push_back(e);
                end
            endcase
        end
    endtask

    bit n8_fin = 1'b0;

    initial begin
        int e8;
        int dc;
        int nb;
        bit seen;
        cmd8.instr = '0;
        cmd8.instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst8_n = 1'b1;
        @(negedge clk);
        cmd8.instr = mk(OP_START, 1'b0, 1'b0, 0, 0, 0);
        cmd8.instr_valid = 1'b1;
        #1;
        chk("n8_ready", cmd8.instr_ready, 1'b1);
        e8 = cyc + 1;
        @(negedge clk);
        cmd8.instr_valid = 1'b0;
        seen = 1'b0;
        dc = -1;
        nb = 0;
        if (busy8) nb++;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done8) begin
                seen = 1'b1;
                dc = cyc;
            end
            if (busy8) nb++;
        end
        chk("n8_done_cycle", dc, e8 + 2 * N8 + N8);
        chk("n8_busy_cycles", nb, 2 * N8 + N8);
        n8_fin = 1'b1;
    end

    initial begin
        cmd.instr = '0;
        cmd.instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outs", {mema_data_in, memb_data_in, mema_write_enable, memb_write_enable,
            mema_write_line, memb_write_line, mema_write_elem, memb_write_elem, read_enable,
            read_elem, array_enable, array_clear, array_output_row, array_output_column,
            busy, done, cmd_error}, 64'd0);
        chk("reset_ready", cmd.instr_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, mk(OP_LOAD, 1'b0, 1'b0, 2, 1, 'h5A));
        drive(1'b1, mk(OP_LOAD, 1'b1, 1'b0, 3, 0, 'hC3));
        drive(1'b1, mk(OP_START, 1'b0, 1'b1, 0, 0, 0));
        repeat (2) drive(1'b0, '0);
        repeat (16) drive(1'b1, mk(OP_LOAD, 1'b0, 1'b0, 1, 3, 'h77));
        drive(1'b1, mk(OP_START, 1'b0, 1'b0, 0, 0, 0));
        repeat (4) drive(1'b0, '0);
        drive(1'b1, mk(OP_STOP, 1'b0, 1'b0, 0, 0, 0));
        drive(1'b1, mk(OP_START, 1'b0, 1'b1, 0, 0, 0));
        repeat (14) drive(1'b0, '0);
        drive(1'b1, mk(OP_STOP, 1'b0, 1'b0, 0, 0, 0));
        drive(1'b1, mk(OP_STORE, 1'b0, 1'b0, 4, 0, 0));
        drive(1'b1, mk(OP_STORE, 1'b0, 1'b0, 3, 2, 0));
        drive(1'b1, mk(OP_LOAD, 1'b1, 1'b0, 0, 5, 'h11));
        drive(1'b1, mk(OP_START, 1'b0, 1'b1, 0, 0, 0));
        repeat (2) drive(1'b0, '0);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outs", {mema_write_enable, memb_write_enable, read_enable, read_elem,
            array_enable, array_clear, array_output_row, array_output_column, busy, done,
            cmd_error, mema_data_in, memb_data_in}, 64'd0);
        chk("async_reset_ready", cmd.instr_ready, 1'b1);
        have_run = 1'b0;
        wr_q.delete();
        st_q.delete();
        err_q.delete();
        exp_row = '0;
        exp_col = '0;
        @(negedge clk);
        #3 rst_n = 1'b1;

        repeat (1500) begin
            bit v;
            int r;
            logic [1:0] op;
            v = $urandom_range(0, 99) < 70;
            r = $urandom_range(0, 99);
            op = (r < 20) ? OP_START : (r < 25) ? OP_STOP : (r < 65) ? OP_LOAD : OP_STORE;
            drive(v, mk(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 255)));
        end
        repeat (30) drive(1'b0, '0);
        chk("queues_drained", wr_q.size() + st_q.size() + err_q.size(), 0);
        chk("n8_finished", n8_fin, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
